// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Brief    : Sequences one ALU request at a time: latch, load operands, wait
//            for the ALU to settle, then hold the result until consumed.
//            Optional macro ALU_SEQ_HILO_EN adds mul/div high-word capture.
// Revision : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
    parameter int MULDIV_WAIT = 4
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [4:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [63:0] alu_c,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_lo,
    output logic [31:0] rsp_hi,
    output logic        rsp_err,
    output logic        busy
);

    localparam int c_wait  = (MULDIV_WAIT < 1) ? 1 : MULDIV_WAIT;
    localparam int c_cnt_w = (c_wait > 1) ? $clog2(c_wait) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(c_wait - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [4:0] c_op_div  = 5'b01111;
    localparam logic [4:0] c_op_mul  = 5'b10000;
    localparam logic [4:0] c_op_last = 5'b10011;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD_Y = 2'd1,
        S_EXEC   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [4:0]           r_op;
    logic [31:0]          r_a;
    logic [31:0]          r_b;
    logic [4:0]           r_alu_op;
    logic [31:0]          r_alu_a;
    logic [31:0]          r_alu_b;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [31:0]          r_rsp_lo;
    logic                 r_rsp_err;
    logic                 w_req_illegal;
    logic                 w_load_muldiv;
    logic                 w_exec_done;

    assign w_req_illegal = (req_op > c_op_last);
    assign w_load_muldiv = (r_op == c_op_mul) || (r_op == c_op_div);
    assign w_exec_done   = (r_cnt == '0);

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (req_valid) w_next = w_req_illegal ? S_RESP : S_LOAD_Y;
            S_LOAD_Y: w_next = S_EXEC;
            S_EXEC:   if (w_exec_done) w_next = S_RESP;
            S_RESP:   if (rsp_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // The counter is preloaded in LOAD_Y so EXEC exits when it reads zero.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_alu_op  <= '0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_cnt     <= '0;
            r_rsp_lo  <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op <= req_op;
                        r_a  <= req_a;
                        r_b  <= req_b;
                        if (w_req_illegal) begin
                            r_rsp_lo  <= '0;
                            r_rsp_err <= 1'b1;
                        end
                    end
                end
                S_LOAD_Y: begin
                    r_alu_op <= r_op;
                    r_alu_a  <= r_a;
                    r_alu_b  <= r_b;
                    r_cnt    <= w_load_muldiv ? c_cnt_load : '0;
                end
                S_EXEC: begin
                    if (w_exec_done) begin
                        r_rsp_lo  <= alu_c[31:0];
                        r_rsp_err <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_SEQ_HILO_EN
    logic [31:0] r_rsp_hi;
    logic        w_exec_muldiv;

    assign w_exec_muldiv = (r_alu_op == c_op_mul) || (r_alu_op == c_op_div);

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_rsp_hi <= '0;
        end else if ((r_state == S_IDLE) && req_valid && w_req_illegal) begin
            r_rsp_hi <= '0;
        end else if ((r_state == S_EXEC) && w_exec_done) begin
            r_rsp_hi <= w_exec_muldiv ? alu_c[63:32] : '0;
        end
    end

    assign rsp_hi = r_rsp_hi;
`else
    logic w_unused_hi;

    assign w_unused_hi = ^alu_c[63:32];
    assign rsp_hi      = '0;
`endif

    assign alu_op    = r_alu_op;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign rsp_lo    = r_rsp_lo;
    assign rsp_err   = r_rsp_err;
    assign rsp_valid = (r_state == S_RESP);
    assign req_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sequencer
// Brief    : Self-checking bench for alu_sequencer with a behavioural ALU and
//            a transaction-level reference model (result, latency, hold).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

    localparam int W = 4;

    logic        clk = 1'b0;
    logic        clear;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [63:0] alu_c;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_lo;
    logic [31:0] rsp_hi;
    logic        rsp_err;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;

    // Model of what the ALU drive registers should currently hold.
    logic [4:0]  m_op;
    logic [31:0] m_a;
    logic [31:0] m_b;

    alu_sequencer #(.MULDIV_WAIT(W)) dut (
        .clk(clk), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_lo(rsp_lo), .rsp_hi(rsp_hi), .rsp_err(rsp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            5'd3:  return {32'hA5A5_0001, a + b};
            5'd4:  return {32'h5A5A_0002, a - b};
            5'd16: return {32'h0, a} * {32'h0, b};
            5'd15: return (b == 32'h0) ? 64'hFFFF_FFFF_FFFF_FFFF : {a % b, a / b};
            default: return {27'h0, op, a ^ (b + 32'(op))};
        endcase
    endfunction

    always_comb alu_c = alu_fn(alu_op, alu_a, alu_b);

    task automatic drive_junk();
        req_valid = 1'($urandom_range(0, 1));
        req_op    = 5'($urandom);
        req_a     = $urandom;
        req_b     = $urandom;
    endtask

    // Issue one request at a negedge and follow it to the end of the handshake.
    task automatic do_txn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic        illegal;
        logic        muldiv;
        int          exp_lat;
        int          lat;
        logic [63:0] res;
        logic [31:0] exp_lo;
        logic [31:0] exp_hi;
        illegal = (op > 5'd19);
        muldiv  = (op == 5'd16) || (op == 5'd15);
        exp_lat = illegal ? 0 : (muldiv ? 1 + W : 2);
        res     = alu_fn(op, a, b);
        exp_lo  = illegal ? 32'h0 : res[31:0];
`ifdef ALU_SEQ_HILO_EN
        exp_hi  = (!illegal && muldiv) ? res[63:32] : 32'h0;
`else
        exp_hi  = 32'h0;
`endif
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_bad++; $display("FAIL idle_ready: got %0b expected 1", req_ready);
        end
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; rsp_ready = 1'b0;
        @(negedge clk);
        if (!illegal) begin
            m_op = op; m_a = a; m_b = b;
        end
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 100) begin
            n_vec++;
            if (req_ready !== 1'b0 || busy !== 1'b1) begin
                n_bad++; $display("FAIL busy_flags: got ready=%0b busy=%0b expected ready=0 busy=1", req_ready, busy);
            end
            drive_junk();
            rsp_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        rsp_ready = 1'b0;
        n_vec++;
        if (lat != exp_lat) begin
            n_bad++; $display("FAIL latency op=%0h: got %0d expected %0d", op, lat, exp_lat);
            if (lat >= 100) return;
        end
        n_vec++;
        if (rsp_lo !== exp_lo || rsp_hi !== exp_hi || rsp_err !== illegal) begin
            n_bad++;
            $display("FAIL result op=%0h: got lo=%0h hi=%0h err=%0b expected lo=%0h hi=%0h err=%0b",
                     op, rsp_lo, rsp_hi, rsp_err, exp_lo, exp_hi, illegal);
        end
        n_vec++;
        if (alu_op !== m_op || alu_a !== m_a || alu_b !== m_b) begin
            n_bad++;
            $display("FAIL alu_drive: got %0h/%0h/%0h expected %0h/%0h/%0h", alu_op, alu_a, alu_b, m_op, m_a, m_b);
        end
        for (int i = 0; i < hold; i++) begin
            drive_junk();
            @(negedge clk);
            n_vec++;
            if (rsp_valid !== 1'b1 || rsp_lo !== exp_lo || rsp_hi !== exp_hi || rsp_err !== illegal || alu_op !== m_op) begin
                n_bad++;
                $display("FAIL hold cycle %0d: got valid=%0b lo=%0h hi=%0h err=%0b op=%0h expected valid=1 lo=%0h hi=%0h err=%0b op=%0h",
                         i, rsp_valid, rsp_lo, rsp_hi, rsp_err, alu_op, exp_lo, exp_hi, illegal, m_op);
            end
        end
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_op = 5'd3; req_a = $urandom; req_b = $urandom;
        n_vec++;
        if (req_ready !== 1'b0) begin
            n_bad++; $display("FAIL turnaround_ready: got %0b expected 0", req_ready);
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        n_vec++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL after_handshake: got valid=%0b busy=%0b ready=%0b expected 0/0/1", rsp_valid, busy, req_ready);
        end
    endtask

    task automatic test_reset();
        clear = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        m_op = '0; m_a = '0; m_b = '0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_lo !== 32'h0 || rsp_hi !== 32'h0 || rsp_err !== 1'b0 ||
            alu_op !== 5'h0 || alu_a !== 32'h0 || alu_b !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_state: got valid=%0b busy=%0b lo=%0h hi=%0h err=%0b op=%0h expected all zero",
                     rsp_valid, busy, rsp_lo, rsp_hi, rsp_err, alu_op);
        end
        clear = 1'b0;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_ready: got %0b expected 1", req_ready);
        end
    endtask

    task automatic test_add();
        do_txn(5'b00011, 32'd5, 32'd7, 0);
        n_vec++;
        if (m_op !== 5'd3 || alu_fn(5'd3, 32'd5, 32'd7) !== {32'hA5A5_0001, 32'd12}) begin
            n_bad++; $display("FAIL add_model: got %0h expected 12", m_op);
        end
    endtask

    task automatic test_mul();
        do_txn(5'b10000, 32'h0001_0000, 32'h0001_0000, 1);
    endtask

    task automatic test_illegal();
        do_txn(5'b11111, $urandom, $urandom, 2);
        do_txn(5'b10100, $urandom, $urandom, 0);
    endtask

    task automatic test_stall();
        do_txn(5'b00100, 32'd10, 32'd3, 5);
    endtask

    task automatic test_clear_mid();
        req_valid = 1'b1; req_op = 5'b01111; req_a = 32'd100; req_b = 32'd7;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #1 clear = 1'b1;
        #1;
        n_vec++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || alu_op !== 5'h0 || alu_a !== 32'h0 || alu_b !== 32'h0 ||
            rsp_lo !== 32'h0 || rsp_hi !== 32'h0 || rsp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL async_clear: got valid=%0b busy=%0b op=%0h a=%0h lo=%0h expected all zero",
                     rsp_valid, busy, alu_op, alu_a, rsp_lo);
        end
        #1 clear = 1'b0;
        m_op = '0; m_a = '0; m_b = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_vec++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                n_bad++; $display("FAIL discarded_op cycle %0d: got valid=%0b busy=%0b expected 0/0", i, rsp_valid, busy);
            end
        end
        do_txn(5'b00011, 32'd1, 32'd1, 0);
    endtask

    task automatic test_back_to_back();
        do_txn(5'b00000, $urandom, $urandom, 0);
        do_txn(5'b10011, $urandom, $urandom, 0);
        do_txn(5'b01111, $urandom, 32'd0, 0);
    endtask

    task automatic test_random();
        logic [4:0] op;
        int         sel;
        for (int t = 0; t < 30; t++) begin
            sel = $urandom_range(0, 9);
            if (sel < 2)       op = 5'd16;
            else if (sel == 2) op = 5'd15;
            else if (sel == 3) op = 5'($urandom_range(20, 31));
            else               op = 5'($urandom_range(0, 19));
            do_txn(op, $urandom, $urandom, $urandom_range(0, 3));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_illegal();
        test_stall();
        test_clear_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter MULDIV_WAIT, default 4, EXEC cycles spent on mul (10000) and div (01111); values below 1 SHALL behave as 1.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 clear  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  request offered.
REQ-005 req_ready  output  1  sequencer can accept a request.
REQ-006 req_op / req_a / req_b  input  5/32/32  opcode, operand A (Y path), operand B (bus path).
REQ-007 alu_op / alu_a / alu_b  output  5/32/32  registered drives to the ALU's op_code, a, b.
REQ-008 alu_c  input  64  ALU result (combinational from alu_op/alu_a/alu_b).
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts result.
REQ-011 rsp_lo / rsp_hi / rsp_err  output  32/32/1  result low word, high word, illegal-opcode flag.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 States SHALL be IDLE, LOAD_Y, EXEC, RESP; req_ready=1 only in IDLE.
REQ-014 IDLE with req_valid=1: on the edge, latch req_op/req_a/req_b; legal opcode (00000-10011) -> LOAD_Y; opcode 10100-11111 -> RESP with rsp_err=1, rsp_lo=rsp_hi=0.
REQ-015 LOAD_Y lasts one cycle: alu_a<=latched A, alu_b<=latched B, alu_op<=latched opcode; -> EXEC.
REQ-016 EXEC: non-mul/div lasts 1 cycle; mul/div lasts MULDIV_WAIT cycles counted by an internal down-counter; on the final EXEC edge capture alu_c and -> RESP.
REQ-017 Capture: rsp_lo<=alu_c[31:0]; rsp_hi per REQ-024/025; rsp_err<=0.
REQ-018 Latency: legal non-mul/div request accepted on edge E0 -> rsp_valid high after edge E0+2; mul/div -> after E0+1+MULDIV_WAIT; illegal -> after E0.
REQ-019 RESP: rsp_valid=1; rsp_lo/rsp_hi/rsp_err and alu_* SHALL hold stable until rsp_ready=1; on that edge -> IDLE.
REQ-020 No same-cycle turnaround: req_ready SHALL be 0 in the cycle rsp handshake completes; next request accepted no earlier than the following edge.
REQ-021 req_valid, req_op/req_a/req_b changes outside IDLE SHALL be ignored.
REQ-022 ld, ldi, st, br, addi SHALL be sequenced identically to add (single EXEC cycle).

Reset
REQ-023 clear=1 SHALL immediately, independent of clk, force IDLE, counter 0, alu_op=alu_a=alu_b=0, rsp_valid=0, rsp_lo=rsp_hi=0, rsp_err=0, busy=0, req_ready=1 (after release); an in-flight operation is discarded with no response.

Configuration
REQ-024 With ALU_SEQ_HILO_EN defined: mul/div capture rsp_hi<=alu_c[63:32]; all other ops rsp_hi<=0.
REQ-025 Without ALU_SEQ_HILO_EN: rsp_hi SHALL be constant 0 and no hi-word capture register synthesised; rsp_lo behaviour unchanged.

Verification
REQ-026 add (00011), A=5, B=7, accept at E0 -> rsp_valid after E0+2, rsp_lo=12, rsp_hi=0, rsp_err=0.
REQ-027 mul (10000), A=0x00010000, B=0x00010000, MULDIV_WAIT=4 -> rsp_valid after E0+5; with ALU_SEQ_HILO_EN rsp_hi=1, rsp_lo=0; without, rsp_hi=0, rsp_lo=0.
REQ-028 opcode 11111 -> rsp_valid after E0, rsp_err=1, rsp_lo=rsp_hi=0, alu_op unchanged.
REQ-029 sub A=10, B=3 with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_lo=7 stable all 5 cycles; IDLE after rsp_ready edge; req_ready 0 in handshake cycle.
REQ-030 div request, clear pulsed mid-EXEC (between edges) -> outputs zero immediately, no rsp_valid; add 1+1 issued after release -> rsp_lo=2 with normal latency.
